// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data handshake bundle for one side of a pipeline stage register.
// The master drives valid/data, the slave drives ready.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with stall, synchronous flush and bubble payload.
// Define PIPE_STAGE_SKID_EN to add a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn,
  output logic [1:0]       occupancy
);

  logic [DATA_W-1:0] main_data;
  logic              main_valid;

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] skid_data;
  logic              accept, consume;
  logic              ld_main_in, ld_main_skid, ld_skid;

  // Ready depends only on the state flop, so no combinational path from dn.ready.
  assign up.ready   = (state != TWO);
  assign main_valid = (state != EMPTY);
  assign accept     = up.valid & up.ready;
  assign consume    = main_valid & dn.ready;
  assign occupancy  = state;

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nxt  = ONE;
        ld_main_in = 1'b1;
      end
      ONE: begin
        if (consume && accept) begin
          ld_main_in = 1'b1;
        end else if (consume) begin
          state_nxt = EMPTY;
        end else if (accept) begin
          state_nxt = TWO;
          ld_skid   = 1'b1;
        end
      end
      TWO: if (consume) begin
        state_nxt    = ONE;
        ld_main_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt    = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      main_data <= BUBBLE_VAL;
      skid_data <= BUBBLE_VAL;
    end else begin
      state <= state_nxt;
      if (ld_main_in)        main_data <= up.data;
      else if (ld_main_skid) main_data <= skid_data;
      if (ld_skid)           skid_data <= up.data;
    end
  end
`else
  // A stalled beat leaves the slot as soon as downstream takes it.
  assign up.ready  = dn.ready | ~main_valid;
  assign occupancy = {1'b0, main_valid};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_data  <= BUBBLE_VAL;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_data  <= BUBBLE_VAL;
    end else if (up.ready) begin
      main_valid <= up.valid;
      main_data  <= up.valid ? up.data : BUBBLE_VAL;
    end
  end
`endif

  assign dn.valid = main_valid;
  assign dn.data  = main_valid ? main_data : BUBBLE_VAL;

endmodule
